sram_xbar_n: RTL and testbench

//  Parametrised successor to the two-way SRAM crossbar: one SRAM-style master fans out to N_SLAVE slaves.

---
 rtl/sram_xbar_n.sv | 132 +++++++++++++
 tb/tb_sram_xbar_n.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_xbar_n.sv
// sram_xbar_n: one SRAM master fanned out to N_SLAVE slaves by base/mask address decode, with decode-error logging
module sram_xbar_n #(
  parameter int                            N_SLAVE       = 3,
  parameter int                            LEN_ADDR      = 64,
  parameter int                            LEN_DATA      = 64,
  parameter logic [N_SLAVE*LEN_ADDR-1:0]   SLV_BASE      = {64'h6000_0000, 64'h6400_0000, 64'h8000_0000},
  parameter logic [N_SLAVE*LEN_ADDR-1:0]   SLV_MASK      = {64'hF000_0000, 64'hFF00_0000, 64'hF000_0000},
  parameter bit                            REQ_REG       = 1'b0,
  parameter logic [LEN_DATA-1:0]           DEFAULT_RDATA = '0,
  parameter int                            CNT_W         = 16
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [LEN_ADDR-1:0]                master_addra,
  input  logic [LEN_DATA-1:0]                master_dina,
  output logic [LEN_DATA-1:0]                master_douta,
  input  logic                               master_ena,
  input  logic [LEN_DATA/8-1:0]              master_wea,
  output logic [N_SLAVE*LEN_ADDR-1:0]        slave_addra,
  output logic [N_SLAVE*LEN_DATA-1:0]        slave_dina,
  input  logic [N_SLAVE*LEN_DATA-1:0]        slave_douta,
  output logic [N_SLAVE-1:0]                 slave_ena,
  output logic [N_SLAVE*(LEN_DATA/8)-1:0]    slave_wea,
  output logic                               decerr,
  output logic [LEN_ADDR-1:0]                decerr_addr,
  output logic [CNT_W-1:0]                   decerr_cnt,
  input  logic                               decerr_clr
);
  localparam int LEN_WE = LEN_DATA / 8;
  localparam int SEL_W  = N_SLAVE > 1 ? $clog2(N_SLAVE) : 1;

  logic [LEN_ADDR-1:0] w_addr;
  logic [LEN_DATA-1:0] w_din;
  logic [LEN_WE-1:0]   w_wea;
  logic                w_ena;
  logic                w_hit;
  logic [SEL_W-1:0]    w_sel;
  logic                w_miss;
  logic                r_sel_vld;
  logic [SEL_W-1:0]    r_sel;
  logic                r_err;
  logic [LEN_ADDR-1:0] r_eaddr;
  logic [CNT_W-1:0]    r_cnt;

  generate
    if (REQ_REG) begin : g_req_reg
      logic [LEN_ADDR-1:0] r_addr;
      logic [LEN_DATA-1:0] r_din;
      logic [LEN_WE-1:0]   r_wea;
      logic                r_ena;
      // request stage: capture the master every cycle; reset leaves an idle request so an in-flight write is aborted
      always_ff @(posedge clk) begin
        if (!rstn) begin
          r_addr <= '0;
          r_din  <= '0;
          r_wea  <= '0;
          r_ena  <= 1'b0;
        end else begin
          r_addr <= master_addra;
          r_din  <= master_dina;
          r_wea  <= master_wea;
          r_ena  <= master_ena;
        end
      end
      assign w_addr = r_addr;
      assign w_din  = r_din;
      assign w_wea  = r_wea;
      assign w_ena  = r_ena;
    end else begin : g_req_comb
      assign w_addr = master_addra;
      assign w_din  = master_dina;
      assign w_wea  = master_wea;
      assign w_ena  = master_ena;
    end
  endgenerate

  // address decode: scan high to low so the lowest hitting slave index is the one that sticks
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = N_SLAVE - 1; i >= 0; i--)
      if ((w_addr & SLV_MASK[i*LEN_ADDR +: LEN_ADDR]) ==
          (SLV_BASE[i*LEN_ADDR +: LEN_ADDR] & SLV_MASK[i*LEN_ADDR +: LEN_ADDR])) begin
        w_hit = 1'b1;
        w_sel = SEL_W'(i);
      end
  end

  assign w_miss      = w_ena & ~w_hit;
  assign slave_addra = {N_SLAVE{w_addr}};
  assign slave_dina  = {N_SLAVE{w_din}};

  // enables and byte strobes reach only the winning slave; a miss enables nobody so its write is dropped
  always_comb begin
    slave_ena = '0;
    slave_wea = '0;
    if (w_ena && w_hit) begin
      slave_ena[w_sel]                  = 1'b1;
      slave_wea[w_sel*LEN_WE +: LEN_WE] = w_wea;
    end
  end

  // response select: remember who was last accessed so read data holds like a plain SRAM between accesses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sel_vld <= 1'b0;
      r_sel     <= '0;
    end else if (w_ena) begin
      r_sel_vld <= w_hit;
      r_sel     <= w_sel;
    end
  end

  assign master_douta = r_sel_vld ? slave_douta[r_sel*LEN_DATA +: LEN_DATA] : DEFAULT_RDATA;

  // decode-error log: a new miss beats a simultaneous clear, the count saturates, the address survives a clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err   <= 1'b0;
      r_eaddr <= '0;
      r_cnt   <= '0;
    end else begin
      r_err   <= w_miss | (r_err & ~decerr_clr);
      r_cnt   <= w_miss ? (decerr_clr ? CNT_W'(1) : r_cnt + CNT_W'(~&r_cnt)) : (decerr_clr ? '0 : r_cnt);
      r_eaddr <= w_miss ? w_addr : r_eaddr;
    end
  end

  assign decerr      = r_err;
  assign decerr_addr = r_eaddr;
  assign decerr_cnt  = r_cnt;
endmodule

// File: tb/tb_sram_xbar_n.sv
// tb_sram_xbar_n: vector table plus scoreboard for the combinational crossbar, hand sequences for the registered/saturating variant
module tb_sram_xbar_n;
  localparam int N  = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int WE = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   a_addr = '0;
  logic [DW-1:0]   a_din = '0;
  logic [DW-1:0]   a_douta;
  logic            a_ena = 1'b0;
  logic [WE-1:0]   a_wea = '0;
  logic [N*AW-1:0] a_saddr;
  logic [N*DW-1:0] a_sdin;
  logic [N*DW-1:0] a_sdouta;
  logic [N-1:0]    a_sena;
  logic [N*WE-1:0] a_swea;
  logic            a_err;
  logic [AW-1:0]   a_eaddr;
  logic [15:0]     a_cnt;
  logic            a_clr = 1'b0;

  logic [AW-1:0]   b_addr = '0;
  logic [DW-1:0]   b_din = '0;
  logic [DW-1:0]   b_douta;
  logic            b_ena = 1'b0;
  logic [WE-1:0]   b_wea = '0;
  logic [N*AW-1:0] b_saddr;
  logic [N*DW-1:0] b_sdin;
  logic [N-1:0]    b_sena;
  logic [N*WE-1:0] b_swea;
  logic            b_err;
  logic [AW-1:0]   b_eaddr;
  logic [1:0]      b_cnt;
  logic            b_clr = 1'b0;

  sram_xbar_n dut0 (
    .clk(clk), .rstn(rstn),
    .master_addra(a_addr), .master_dina(a_din), .master_douta(a_douta),
    .master_ena(a_ena), .master_wea(a_wea),
    .slave_addra(a_saddr), .slave_dina(a_sdin), .slave_douta(a_sdouta),
    .slave_ena(a_sena), .slave_wea(a_swea),
    .decerr(a_err), .decerr_addr(a_eaddr), .decerr_cnt(a_cnt), .decerr_clr(a_clr)
  );

  sram_xbar_n #(.REQ_REG(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rstn(rstn),
    .master_addra(b_addr), .master_dina(b_din), .master_douta(b_douta),
    .master_ena(b_ena), .master_wea(b_wea),
    .slave_addra(b_saddr), .slave_dina(b_sdin), .slave_douta({64'hC2, 64'hC1, 64'hC0}),
    .slave_ena(b_sena), .slave_wea(b_swea),
    .decerr(b_err), .decerr_addr(b_eaddr), .decerr_cnt(b_cnt), .decerr_clr(b_clr)
  );

  // SRAM slaves behind dut0: read-first, one cycle latency, byte writes
  logic [DW-1:0] mem [N][16];
  logic [DW-1:0] rd_q [N];
  logic          ovr = 1'b0;
  logic [DW-1:0] ovr_val = '0;
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (a_sena[i]) begin
        rd_q[i] <= mem[i][a_saddr[i*AW+3 +: 4]];
        for (int b = 0; b < WE; b++)
          if (a_swea[i*WE+b]) mem[i][a_saddr[i*AW+3 +: 4]][b*8 +: 8] <= a_sdin[i*DW+b*8 +: 8];
      end
  assign a_sdouta = {rd_q[2], rd_q[1], ovr ? ovr_val : rd_q[0]};

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [WE-1:0] wea;
    logic          ena;
    logic [N-1:0]  sel;
  } vec_t;

  localparam int NV = 16;
  vec_t          tv [NV];
  logic [DW-1:0] ref_mem [N][16];
  logic [DW-1:0] sb [$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int            idx;
    int            w;
    int            exp_cnt;
    logic [N*WE-1:0] exp_wea;
    tv[0]  = '{64'h8000_0010, 64'h1111_1111_1111_1111, 8'hFF, 1'b1, 3'b001};
    tv[1]  = '{64'h6400_0008, 64'h2222_2222_2222_2222, 8'hFF, 1'b1, 3'b010};
    tv[2]  = '{64'h6000_0000, 64'h3333_3333_3333_3333, 8'hFF, 1'b1, 3'b100};
    tv[3]  = '{64'h6000_0008, 64'h4444_4444_4444_4444, 8'hFF, 1'b1, 3'b100};
    tv[4]  = '{64'h6000_0008, 64'h5555_5555_5555_5555, 8'h0F, 1'b1, 3'b100};
    tv[5]  = '{64'h8000_0010, 64'h0, 8'h00, 1'b1, 3'b001};
    tv[6]  = '{64'h6400_0008, 64'h0, 8'h00, 1'b1, 3'b010};
    tv[7]  = '{64'h6000_0000, 64'h0, 8'h00, 1'b1, 3'b100};
    tv[8]  = '{64'h6000_0008, 64'h0, 8'h00, 1'b1, 3'b100};
    tv[9]  = '{64'h1000_0000, 64'h0, 8'h00, 1'b1, 3'b000};
    tv[10] = '{64'h1000_0000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1, 3'b000};
    tv[11] = '{64'h8000_0010, 64'h0, 8'h00, 1'b0, 3'b000};
    tv[12] = '{64'h64F0_0008, 64'h0, 8'h00, 1'b1, 3'b010};
    tv[13] = '{64'h8FFF_FF10, 64'h0, 8'h00, 1'b1, 3'b001};
    tv[14] = '{64'h6500_0000, 64'h0, 8'h00, 1'b1, 3'b100};
    tv[15] = '{64'h1000_0000, 64'h0, 8'h00, 1'b1, 3'b000};
    exp_cnt = 0;

    step();
    step();
    chk("reset a_douta", a_douta, 64'h0);
    chk("reset a_decerr", {63'h0, a_err}, 64'h0);
    chk("reset a_cnt", {48'h0, a_cnt}, 64'h0);
    chk("reset a_eaddr", a_eaddr, 64'h0);
    chk("reset a_sena", {61'h0, a_sena}, 64'h0);
    chk("reset b_douta", b_douta, 64'h0);
    chk("reset b_sena", {61'h0, b_sena}, 64'h0);
    rstn = 1'b1;
    step();

    for (int k = 0; k < NV; k++) begin
      a_addr = tv[k].addr;
      a_din  = tv[k].din;
      a_wea  = tv[k].wea;
      a_ena  = tv[k].ena;
      #1;
      exp_wea = '0;
      for (int i = 0; i < N; i++)
        if (tv[k].sel[i]) exp_wea[i*WE +: WE] = tv[k].wea;
      chk($sformatf("v%0d slave_ena", k), {61'h0, a_sena}, {61'h0, tv[k].sel});
      chk($sformatf("v%0d slave_wea", k), {40'h0, a_swea}, {40'h0, exp_wea});
      chk($sformatf("v%0d slave_addra", k), a_saddr[(k%N)*AW +: AW], tv[k].addr);
      chk($sformatf("v%0d slave_dina", k), a_sdin[(k%N)*DW +: DW], tv[k].din);
      idx = tv[k].sel[0] ? 0 : tv[k].sel[1] ? 1 : 2;
      w = int'(tv[k].addr[6:3]);
      if (tv[k].ena && tv[k].wea == '0)
        sb.push_back(tv[k].sel == '0 ? 64'h0 : ref_mem[idx][w]);
      if (tv[k].ena && tv[k].wea != '0 && tv[k].sel != '0)
        for (int b = 0; b < WE; b++)
          if (tv[k].wea[b]) ref_mem[idx][w][b*8 +: 8] = tv[k].din[b*8 +: 8];
      if (tv[k].ena && tv[k].sel == '0) exp_cnt++;
      step();
      if (sb.size() > 0) chk($sformatf("v%0d master_douta", k), a_douta, sb.pop_front());
      chk($sformatf("v%0d decerr_cnt", k), {48'h0, a_cnt}, 64'(exp_cnt));
    end
    chk("miss decerr", {63'h0, a_err}, 64'h1);
    chk("miss decerr_addr", a_eaddr, 64'h1000_0000);

    a_addr = 64'h8000_0010;
    a_wea  = '0;
    a_ena  = 1'b1;
    step();
    a_ena = 1'b0;
    chk("hold first read", a_douta, 64'h1111_1111_1111_1111);
    ovr_val = 64'hAA;
    ovr = 1'b1;
    #1;
    chk("hold tracks AA", a_douta, 64'hAA);
    step();
    ovr_val = 64'hBB;
    for (int i = 0; i < 4; i++) step();
    chk("hold tracks BB", a_douta, 64'hBB);
    ovr = 1'b0;

    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("clr decerr", {63'h0, a_err}, 64'h0);
    chk("clr cnt", {48'h0, a_cnt}, 64'h0);
    chk("clr keeps addr", a_eaddr, 64'h1000_0000);

    b_addr = 64'h8000_0010;
    b_ena  = 1'b1;
    #1;
    chk("reg no comb ena", {61'h0, b_sena}, 64'h0);
    step();
    b_ena = 1'b0;
    chk("reg stage ena", {61'h0, b_sena}, 64'h1);
    chk("reg douta not yet", b_douta, 64'h0);
    step();
    chk("reg douta 2 cycles", b_douta, 64'hC0);
    chk("reg stage idle", {61'h0, b_sena}, 64'h0);

    b_addr = 64'h1000_0000;
    b_ena  = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      chk($sformatf("sat cnt step%0d", j), {62'h0, b_cnt}, 64'(j < 3 ? j : 3));
    end
    b_ena = 1'b0;
    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    chk("miss+clr cnt", {62'h0, b_cnt}, 64'h1);
    chk("miss+clr decerr", {63'h0, b_err}, 64'h1);
    step();
    chk("after clr cnt", {62'h0, b_cnt}, 64'h1);

    b_addr = 64'h8000_0000;
    b_din  = 64'h7777_7777_7777_7777;
    b_wea  = 8'hFF;
    b_ena  = 1'b1;
    rstn   = 1'b0;
    step();
    rstn  = 1'b1;
    b_ena = 1'b0;
    b_wea = '0;
    chk("rst abort wea", {40'h0, b_swea}, 64'h0);
    chk("rst abort ena", {61'h0, b_sena}, 64'h0);
    chk("rst b_douta", b_douta, 64'h0);
    chk("rst b_decerr", {63'h0, b_err}, 64'h0);
    chk("rst b_cnt", {62'h0, b_cnt}, 64'h0);
    chk("rst b_eaddr", b_eaddr, 64'h0);
    chk("rst a_douta", a_douta, 64'h0);
    step();
    chk("post rst wea", {40'h0, b_swea}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
